cordic_input_seq: RTL and testbench
===================================

# cordic_input_seq

Operand-entry sequencer sitting directly upstream of the CORDIC core and display path. It turns single-cycle `st` strobes and the 16-bit switch bus into a function code and two Q2.14 operands, then issues a one-cycle start to the core. It waits for the core's done pulse, then holds the result for display until the next strobe restarts entry.

## Interface
- `W`, 16, operand/result width (Q2.14: 0x4000 = 1.0)
- `FN_W`, 4, function-code width (taken from `sw_in[FN_W-1:0]`)
- `NUM_FN`, 9, valid function codes are 0..NUM_FN-1
- `TIMEOUT`, 64, max cycles in RUN waiting for `core_done`
- `clk` in 1: sole clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `st` in 1: entry strobe, one cycle wide
- `sw_in` in W: switch value sampled on accepted strobe
- `core_done` in 1: core completion pulse
- `core_result` in W: core output, valid when `core_done`=1
- `fn` out FN_W: latched function code
- `op1` out W: latched operand 1
- `op2` out W: latched operand 2
- `core_start` out 1: one-cycle start pulse to core
- `disp_val` out W: value for the seven-segment driver
- `state_o` out 3: current state encoding
- `busy` out 1: high in GO-issued/RUN
- `err` out 1: sticky until next accepted FN strobe; set on bad code or timeout

## Operation
- States: FN=0, OP1=1, OP2=2, GO=3, RUN=4, RESULT=5; codes 6 and 7 are unreachable and return to FN.
- FN, on `st`:
  - if `sw_in[FN_W-1:0]` < NUM_FN: `fn`<=code, `err`<=0, go to OP1.
  - otherwise `err`<=1 and stay in FN; `fn` is unchanged.
- OP1, on `st`: `op1`<=`sw_in`, go to OP2.
- OP2, on `st`: `op2`<=`sw_in`, go to GO.
- GO, on `st`: go to RUN and assert `core_start` for exactly one cycle. The wait counter clears.
- RUN:
  - `st` is ignored.
  - On `core_done`: result register <= `core_result`, go to RESULT.
  - When the counter reaches TIMEOUT-1 without `core_done`: result <= 0, `err`<=1, go to RESULT.
- RESULT, on `st`: go to FN. The result is held until then.
- `disp_val`:
  - registered copy of `sw_in` in FN/OP1/OP2/GO;
  - 0 in RUN;
  - the result register in RESULT.
- `busy` = (state==RUN).
- `core_done` outside RUN is ignored.

## Timing
- Reset values: state=FN; `fn`, `op1`, `op2`, result, `disp_val` and counter are 0; `core_start`=0, `busy`=0, `err`=0.
- All outputs are registered. State changes on the edge that samples `st`.
- `core_start` is high in the cycle immediately after the GO strobe edge, i.e. the first RUN cycle. It is never high for 2 consecutive cycles.
- Latency from `core_done` to RESULT with valid `disp_val` is 1 cycle.
- Timeout fires on the TIMEOUT-th RUN cycle.
- If `core_done` and timeout occur in the same cycle, `core_done` wins and `err` stays 0.
- A `st` held high for multiple cycles advances one state per cycle. The upstream debouncer guarantees single-cycle pulses.
- `rst` takes effect on the next edge from any state, including RUN with the core mid-operation. `core_start` is forced low and the core's later `core_done` is ignored.

## Configuration
- `CORDIC_SEQ_SKIP_OP2_EN`:
  - **Defined:** functions 0, 1 and 7 are two-operand. For all other codes, the OP1 strobe goes directly to GO and `op2` is forced to 0.
  - **Undefined:** every function passes through OP2 and `op2` is always taken from `sw_in`.

## Test plan
- **Full sequence, core answers:** strobes with `sw_in` = 0x0000, 0x4000, 0x2A9B, x; core returns 0x1234 with `core_done` 10 cycles after start.
  - fn=0, op1=0x4000, op2=0x2A9B;
  - `core_start` is a single cycle;
  - `disp_val`=0x1234 in RESULT, `err`=0.
- **Invalid function code:** FN strobe with `sw_in`=0x000C.
  - `err`=1, state stays FN, `fn` unchanged.
  - Next strobe with 0x0002 → OP1 and `err`=0.
- **Timeout:** no `core_done` after start.
  - RESULT entered exactly TIMEOUT cycles after the first RUN cycle;
  - `disp_val`=0, `err`=1.
- **`core_done` and timeout in the same cycle:** result latched from `core_result` and `err`=0.
- **Reset mid-RUN:** assert `rst` mid-RUN, then assert `core_done` later.
  - State=FN and all outputs at reset values;
  - the late `core_done` has no effect.
- **Skip-OP2 path:** with `CORDIC_SEQ_SKIP_OP2_EN` defined, fn=3 then op1=0x2000.
  - Next state is GO and `op2`=0.
  - Without the macro, state goes to OP2.

Source files
------------

// File: rtl/cordic_input_seq_if.sv
// Operand-entry / core-side signal bundle for cordic_input_seq.
// The master modport is the environment (switches, strobe and core); slave is the sequencer.
interface cordic_input_seq_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned FN_W = 4
);
  logic            st;
  logic [W-1:0]    sw_in;
  logic            core_done;
  logic [W-1:0]    core_result;
  logic [FN_W-1:0] fn;
  logic [W-1:0]    op1;
  logic [W-1:0]    op2;
  logic            core_start;
  logic [W-1:0]    disp_val;
  logic [2:0]      state_o;
  logic            busy;
  logic            err;

  modport master (
    output st, sw_in, core_done, core_result,
    input  fn, op1, op2, core_start, disp_val, state_o, busy, err
  );

  modport slave (
    input  st, sw_in, core_done, core_result,
    output fn, op1, op2, core_start, disp_val, state_o, busy, err
  );
endinterface

// File: rtl/cordic_input_seq.sv
// Operand-entry sequencer in front of the CORDIC core: function code, two Q2.14 operands, start, wait, display.
// Optional macro CORDIC_SEQ_SKIP_OP2_EN: single-operand functions bypass OP2 entry with op2 forced to 0.
module cordic_input_seq #(
  parameter int unsigned W       = 16,
  parameter int unsigned FN_W    = 4,
  parameter int unsigned NUM_FN  = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  cordic_input_seq_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FN     = 3'd0,
    S_OP1    = 3'd1,
    S_OP2    = 3'd2,
    S_GO     = 3'd3,
    S_RUN    = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t          state;
  logic [FN_W-1:0] fn;
  logic [W-1:0]    op1;
  logic [W-1:0]    op2;
  logic [W-1:0]    result;
  logic [W-1:0]    disp_val;
  logic [CNT_W-1:0] cnt;
  logic            core_start;
  logic            busy;
  logic            err;

  logic [FN_W-1:0] code;
  logic            code_ok;
  logic            timeout_hit;

  assign code        = bus.sw_in[FN_W-1:0];
  assign code_ok     = {1'b0, code} < (FN_W+1)'(NUM_FN);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef CORDIC_SEQ_SKIP_OP2_EN
  logic two_op;
  assign two_op = (fn == FN_W'(0)) || (fn == FN_W'(1)) || (fn == FN_W'(7));
`endif

  // Single sequencer: every output is registered and updated for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FN;
      fn         <= '0;
      op1        <= '0;
      op2        <= '0;
      result     <= '0;
      disp_val   <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_FN: begin
          disp_val <= bus.sw_in;
          if (bus.st) begin
            if (code_ok) begin
              fn    <= code;
              err   <= 1'b0;
              state <= S_OP1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_OP1: begin
          disp_val <= bus.sw_in;
          if (bus.st) begin
            op1 <= bus.sw_in;
`ifdef CORDIC_SEQ_SKIP_OP2_EN
            if (two_op) begin
              state <= S_OP2;
            end else begin
              op2   <= '0;
              state <= S_GO;
            end
`else
            state <= S_OP2;
`endif
          end
        end
        S_OP2: begin
          disp_val <= bus.sw_in;
          if (bus.st) begin
            op2   <= bus.sw_in;
            state <= S_GO;
          end
        end
        S_GO: begin
          if (bus.st) begin
            core_start <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            disp_val   <= '0;
            state      <= S_RUN;
          end else begin
            disp_val <= bus.sw_in;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          // core_done takes priority over a coincident timeout
          if (bus.core_done) begin
            result   <= bus.core_result;
            disp_val <= bus.core_result;
            busy     <= 1'b0;
            state    <= S_RESULT;
          end else if (timeout_hit) begin
            result   <= '0;
            disp_val <= '0;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= S_RESULT;
          end else begin
            disp_val <= '0;
          end
        end
        S_RESULT: begin
          if (bus.st) begin
            disp_val <= bus.sw_in;
            state    <= S_FN;
          end else begin
            disp_val <= result;
          end
        end
        default: begin
          disp_val <= bus.sw_in;
          busy     <= 1'b0;
          state    <= S_FN;
        end
      endcase
    end
  end

  assign bus.fn         = fn;
  assign bus.op1        = op1;
  assign bus.op2        = op2;
  assign bus.core_start = core_start;
  assign bus.disp_val   = disp_val;
  assign bus.state_o    = state;
  assign bus.busy       = busy;
  assign bus.err        = err;

endmodule

// File: tb/tb_cordic_input_seq.sv
// Directed self-checking bench for cordic_input_seq with hand-computed expectations.
module tb_cordic_input_seq;

  localparam int unsigned W       = 16;
  localparam int unsigned FN_W    = 4;
  localparam int unsigned TIMEOUT = 64;

  localparam logic [2:0] S_FN     = 3'd0;
  localparam logic [2:0] S_OP1    = 3'd1;
  localparam logic [2:0] S_OP2    = 3'd2;
  localparam logic [2:0] S_GO     = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cordic_input_seq_if #(.W(W), .FN_W(FN_W)) bus ();

  cordic_input_seq #(.W(W), .FN_W(FN_W), .NUM_FN(9), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] val);
    bus.sw_in = val;
    bus.st    = 1'b1;
    tick();
    bus.st    = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (bus.state_o != S_RESULT && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    rst              = 1'b1;
    bus.st           = 1'b0;
    bus.sw_in        = '0;
    bus.core_done    = 1'b0;
    bus.core_result  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_state", 32'(bus.state_o), 32'(S_FN));
    check("rst_fn", 32'(bus.fn), 32'h0);
    check("rst_op1", 32'(bus.op1), 32'h0);
    check("rst_op2", 32'(bus.op2), 32'h0);
    check("rst_disp", 32'(bus.disp_val), 32'h0);
    check("rst_start", 32'(bus.core_start), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);

    // Full sequence with the core answering 10 cycles after start
    strobe(16'h0000);
    check("seq_fn_state", 32'(bus.state_o), 32'(S_OP1));
    check("seq_fn", 32'(bus.fn), 32'h0);
    strobe(16'h4000);
    check("seq_op1_state", 32'(bus.state_o), 32'(S_OP2));
    check("seq_op1", 32'(bus.op1), 32'h4000);
    check("seq_disp_sw", 32'(bus.disp_val), 32'h4000);
    strobe(16'h2A9B);
    check("seq_op2_state", 32'(bus.state_o), 32'(S_GO));
    check("seq_op2", 32'(bus.op2), 32'h2A9B);
    strobe(16'h5555);
    check("seq_run_state", 32'(bus.state_o), 32'(S_RUN));
    check("seq_start_r0", 32'(bus.core_start), 32'h1);
    check("seq_busy_r0", 32'(bus.busy), 32'h1);
    check("seq_disp_run", 32'(bus.disp_val), 32'h0);
    for (int i = 1; i <= 10; i++) begin
      bus.st = 1'b0;
      tick();
      check($sformatf("seq_run_r%0d", i), 32'(bus.state_o), 32'(S_RUN));
      check($sformatf("seq_start_r%0d", i), 32'(bus.core_start), 32'h0);
      if (i == 3) begin
        bus.st    = 1'b1;
        bus.sw_in = 16'h000F;
      end
      if (i == 10) begin
        bus.core_done   = 1'b1;
        bus.core_result = 16'h1234;
      end
    end
    tick();
    bus.core_done = 1'b0;
    check("seq_res_state", 32'(bus.state_o), 32'(S_RESULT));
    check("seq_res_disp", 32'(bus.disp_val), 32'h1234);
    check("seq_res_err", 32'(bus.err), 32'h0);
    check("seq_res_busy", 32'(bus.busy), 32'h0);
    bus.core_result = 16'h0000;
    tick();
    tick();
    check("seq_res_hold", 32'(bus.disp_val), 32'h1234);

    // Invalid function code
    strobe(16'h000C);
    check("res_to_fn", 32'(bus.state_o), 32'(S_FN));
    strobe(16'h000C);
    check("bad_state", 32'(bus.state_o), 32'(S_FN));
    check("bad_err", 32'(bus.err), 32'h1);
    check("bad_fn_kept", 32'(bus.fn), 32'h0);
    strobe(16'h0002);
    check("good_state", 32'(bus.state_o), 32'(S_OP1));
    check("good_err", 32'(bus.err), 32'h0);
    check("good_fn", 32'(bus.fn), 32'h2);

    // Timeout: fn=1 is two-operand in every build, so OP2 is always visited
    bus.sw_in = 16'h0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    strobe(16'h0001);
    strobe(16'h1000);
    strobe(16'h2000);
    strobe(16'h0000);
    check("to_run", 32'(bus.state_o), 32'(S_RUN));
    wait_result(200, cyc);
    check("to_cycles", 32'(cyc), 32'(TIMEOUT));
    check("to_disp", 32'(bus.disp_val), 32'h0);
    check("to_err", 32'(bus.err), 32'h1);
    check("to_busy", 32'(bus.busy), 32'h0);

    // core_done coincident with the timeout cycle
    strobe(16'h0000);
    strobe(16'h0000);
    check("tie_err_clr", 32'(bus.err), 32'h0);
    strobe(16'h0100);
    strobe(16'h0200);
    strobe(16'h0000);
    for (int i = 1; i < int'(TIMEOUT); i++) tick();
    check("tie_last_run", 32'(bus.state_o), 32'(S_RUN));
    bus.core_done   = 1'b1;
    bus.core_result = 16'h0ABC;
    tick();
    bus.core_done = 1'b0;
    check("tie_state", 32'(bus.state_o), 32'(S_RESULT));
    check("tie_disp", 32'(bus.disp_val), 32'h0ABC);
    check("tie_err", 32'(bus.err), 32'h0);

    // Skip-OP2 path with fn=3, op1=0x2000
    strobe(16'h0000);
    strobe(16'h0003);
    strobe(16'h2000);
`ifdef CORDIC_SEQ_SKIP_OP2_EN
    check("skip_state", 32'(bus.state_o), 32'(S_GO));
    check("skip_op2", 32'(bus.op2), 32'h0);
`else
    check("noskip_state", 32'(bus.state_o), 32'(S_OP2));
    strobe(16'h3000);
    check("noskip_op2", 32'(bus.op2), 32'h3000);
`endif
    check("skip_op1", 32'(bus.op1), 32'h2000);

    // Reset in the first RUN cycle, late core_done afterwards
    strobe(16'h0000);
    check("mid_run", 32'(bus.state_o), 32'(S_RUN));
    check("mid_start", 32'(bus.core_start), 32'h1);
    bus.sw_in = 16'h0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", 32'(bus.state_o), 32'(S_FN));
    check("mrst_start", 32'(bus.core_start), 32'h0);
    check("mrst_fn", 32'(bus.fn), 32'h0);
    check("mrst_op1", 32'(bus.op1), 32'h0);
    check("mrst_op2", 32'(bus.op2), 32'h0);
    check("mrst_busy", 32'(bus.busy), 32'h0);
    check("mrst_disp", 32'(bus.disp_val), 32'h0);
    tick();
    bus.core_done   = 1'b1;
    bus.core_result = 16'hFFFF;
    tick();
    bus.core_done = 1'b0;
    tick();
    check("late_state", 32'(bus.state_o), 32'(S_FN));
    check("late_disp", 32'(bus.disp_val), 32'h0);
    check("late_err", 32'(bus.err), 32'h0);
    check("late_busy", 32'(bus.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
